// File: rtl/decode_issue_queue.sv
// Decode issue queue: circular buffer between fetch and decode that issues up to
// WIDTH oldest entries per cycle, splitting the group on register, memory and control hazards.
module decode_issue_queue #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         in_valid,
   input  logic [WIDTH*32-1:0]      in_instr,
   input  logic [WIDTH*32-1:0]      in_pc,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_valid,
   output logic [WIDTH*32-1:0]      out_instr,
   output logic [WIDTH*32-1:0]      out_pc,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic [31:0]    instr_mem [DEPTH];
   logic [31:0]    pc_mem    [DEPTH];
   logic [AW-1:0]  head;
   logic [AW-1:0]  tail;

   logic [31:0]    slot_instr [WIDTH];
   logic [31:0]    slot_pc    [WIDTH];
   logic [4:0]     rd_f       [WIDTH];
   logic [4:0]     rs1_f      [WIDTH];
   logic [4:0]     rs2_f      [WIDTH];
   logic [WIDTH-1:0] writes_rd;
   logic [WIDTH-1:0] uses_rs1;
   logic [WIDTH-1:0] uses_rs2;
   logic [WIDTH-1:0] is_mem;
   logic [WIDTH-1:0] is_ctrl;
   logic           split;
   logic [CW-1:0]  enq_cnt;
   logic [CW-1:0]  deq_cnt;

   assign in_ready = (CW'(DEPTH) - count) >= CW'(WIDTH);

   always_comb begin
      for (int k = 0; k < WIDTH; k++) begin
         slot_instr[k] = instr_mem[head + AW'(k)];
         slot_pc[k]    = pc_mem[head + AW'(k)];
         rd_f[k]       = slot_instr[k][11:7];
         rs1_f[k]      = slot_instr[k][19:15];
         rs2_f[k]      = slot_instr[k][24:20];
         writes_rd[k]  = slot_instr[k][6:0] inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                                                   OP_LOAD, OP_IMM, OP_REG};
         uses_rs1[k]   = !(slot_instr[k][6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
         uses_rs2[k]   = slot_instr[k][6:0] inside {OP_REG, OP_STORE, OP_BRANCH};
         is_mem[k]     = slot_instr[k][6:0] inside {OP_LOAD, OP_STORE};
         is_ctrl[k]    = slot_instr[k][6:0] inside {OP_BRANCH, OP_JAL, OP_JALR};
      end
   end

   // Grow the issue group slot by slot; any hazard against an older slot ends it.
   always_comb begin
      out_valid    = '0;
      split        = 1'b0;
      out_valid[0] = (count != '0);
      for (int k = 1; k < WIDTH; k++) begin
         split = is_ctrl[k-1];
         for (int j = 0; j < WIDTH; j++) begin
            if (j < k) begin
               if (writes_rd[j] && (rd_f[j] != 5'd0)) begin
                  if ((uses_rs1[k] && (rs1_f[k] == rd_f[j])) ||
                      (uses_rs2[k] && (rs2_f[k] == rd_f[j])) ||
                      (writes_rd[k] && (rd_f[k] == rd_f[j])))
                     split = 1'b1;
               end
               if (is_mem[k] && is_mem[j])
                  split = 1'b1;
            end
         end
         out_valid[k] = out_valid[k-1] && (count > CW'(k)) && !split;
      end
   end

   always_comb begin
      out_instr = '0;
      out_pc    = '0;
      enq_cnt   = '0;
      deq_cnt   = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (out_valid[k]) begin
            out_instr[32*k +: 32] = slot_instr[k];
            out_pc[32*k +: 32]    = slot_pc[k];
            if (out_ready)
               deq_cnt = deq_cnt + CW'(1);
         end
         if (in_valid[k] && in_ready)
            enq_cnt = enq_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + deq_cnt[AW-1:0];
         tail  <= tail + enq_cnt[AW-1:0];
         count <= count + enq_cnt - deq_cnt;
      end
   end

   // Storage is deliberately unreset; entries outside head..tail are never observed.
   always_ff @(posedge clk) begin
      for (int k = 0; k < WIDTH; k++) begin
         if (in_valid[k] && in_ready) begin
            instr_mem[tail + AW'(k)] <= in_instr[32*k +: 32];
            pc_mem[tail + AW'(k)]    <= in_pc[32*k +: 32];
         end
      end
   end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Scoreboard bench for decode_issue_queue (WIDTH=2, DEPTH=8): directed groups are queued
// as expected issue packets and a negedge monitor compares every group the DUT hands off.
module tb_decode_issue_queue;

   typedef struct packed {
      logic [1:0]  mask;
      logic [63:0] instr;
      logic [63:0] pc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [1:0]  in_valid;
   logic [63:0] in_instr;
   logic [63:0] in_pc;
   logic        in_ready;
   logic [1:0]  out_valid;
   logic [63:0] out_instr;
   logic [63:0] out_pc;
   logic        out_ready;
   logic [3:0]  count;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   localparam logic [31:0] ADDI_X1  = 32'h00100093;
   localparam logic [31:0] ADDI_X2  = 32'h00200113;
   localparam logic [31:0] ADD_X3   = 32'h001081B3;
   localparam logic [31:0] ADDI_X9A = 32'h00100493;
   localparam logic [31:0] ADDI_X9B = 32'h00200493;
   localparam logic [31:0] LW_X5    = 32'h00012283;
   localparam logic [31:0] SW_X6    = 32'h00612223;
   localparam logic [31:0] BEQ_8    = 32'h00000463;
   localparam logic [31:0] ADDI_X7  = 32'h00700393;

   decode_issue_queue #(.WIDTH(2), .DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mkAddi(input int rd);
      return 32'((rd << 20) | (rd << 7) | 32'h13);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h", name, act, want);
      end
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                                input logic [31:0] p0, input logic [31:0] p1);
      in_valid = v;
      in_instr = {i1, i0};
      in_pc    = {p1, p0};
      waitCycle();
      in_valid = 2'b00;
      in_instr = '0;
      in_pc    = '0;
   endtask

   task automatic pushExp(input logic [1:0] m, input logic [31:0] i0, input logic [31:0] i1,
                          input logic [31:0] p0, input logic [31:0] p1);
      exp_q.push_back({m, {i1, i0}, {p1, p0}});
   endtask

   // Pair that must issue as two single-slot groups.
   task automatic splitPair(input string name, input logic [31:0] i0, input logic [31:0] i1,
                            input logic [31:0] pc);
      out_ready = 1'b0;
      applyStimulus(2'b11, i0, i1, pc, pc + 32'd4);
      @(negedge clk);
      checkOutput({name, "_valid"}, 64'(out_valid), 64'h1);
      checkOutput({name, "_count"}, 64'(count), 64'd2);
      pushExp(2'b01, i0, 32'h0, pc, 32'h0);
      pushExp(2'b01, i1, 32'h0, pc + 32'd4, 32'h0);
      waitCycle();
      out_ready = 1'b1;
      waitCycle();
      waitCycle();
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput({name, "_drained"}, 64'(count), 64'd0);
      waitCycle();
   endtask

   // Monitor: every group handed off downstream must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_ready && (out_valid != 2'b00)) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_group: got valid=%b instr=%h pc=%h want none",
                     out_valid, out_instr, out_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({out_valid, out_instr, out_pc} !== e) begin
               bad++;
               $display("[TB] FAIL issue_group: got valid=%b instr=%h pc=%h want valid=%b instr=%h pc=%h",
                        out_valid, out_instr, out_pc, e.mask, e.instr, e.pc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time=%0t limit=200000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 2'b00;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      #3;
      checkOutput("reset_count", 64'(count), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      waitCycle();
      waitCycle();
      rst = 1'b0;

      $display("[TB] independent pair");
      applyStimulus(2'b11, ADDI_X1, ADDI_X2, 32'h100, 32'h104);
      @(negedge clk);
      checkOutput("pair_count", 64'(count), 64'd2);
      checkOutput("pair_valid", 64'(out_valid), 64'h3);
      checkOutput("pair_in_ready", 64'(in_ready), 64'd1);
      pushExp(2'b11, ADDI_X1, ADDI_X2, 32'h100, 32'h104);
      waitCycle();
      out_ready = 1'b1;
      waitCycle();
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("pair_drained", 64'(count), 64'd0);
      checkOutput("pair_empty_valid", 64'(out_valid), 64'd0);
      waitCycle();

      $display("[TB] hazard splits");
      splitPair("raw", ADDI_X1, ADD_X3, 32'h200);
      splitPair("waw", ADDI_X9A, ADDI_X9B, 32'h240);
      splitPair("struct", LW_X5, SW_X6, 32'h300);
      splitPair("ctrl", BEQ_8, ADDI_X7, 32'h340);

      $display("[TB] full and wrap");
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b11, mkAddi(8 + 2*i), mkAddi(9 + 2*i), 32'h400 + 32'(8*i), 32'h404 + 32'(8*i));
         pushExp(2'b11, mkAddi(8 + 2*i), mkAddi(9 + 2*i), 32'h400 + 32'(8*i), 32'h404 + 32'(8*i));
      end
      @(negedge clk);
      checkOutput("full_count", 64'(count), 64'd8);
      checkOutput("full_in_ready", 64'(in_ready), 64'd0);
      waitCycle();
      applyStimulus(2'b11, mkAddi(30), mkAddi(31), 32'hBAD0, 32'hBAD4);
      @(negedge clk);
      checkOutput("full_ignored", 64'(count), 64'd8);
      waitCycle();
      out_ready = 1'b1;
      waitCycle();
      waitCycle();
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("half_drain_count", 64'(count), 64'd4);
      checkOutput("half_drain_ready", 64'(in_ready), 64'd1);
      waitCycle();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(2'b11, mkAddi(16 + 2*i), mkAddi(17 + 2*i), 32'h420 + 32'(8*i), 32'h424 + 32'(8*i));
         pushExp(2'b11, mkAddi(16 + 2*i), mkAddi(17 + 2*i), 32'h420 + 32'(8*i), 32'h424 + 32'(8*i));
      end
      @(negedge clk);
      checkOutput("refill_count", 64'(count), 64'd8);
      waitCycle();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) waitCycle();
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("wrap_drained", 64'(count), 64'd0);
      waitCycle();

      $display("[TB] flush with enqueue");
      applyStimulus(2'b11, mkAddi(1), mkAddi(2), 32'h500, 32'h504);
      applyStimulus(2'b11, mkAddi(3), mkAddi(4), 32'h508, 32'h50C);
      applyStimulus(2'b01, mkAddi(5), 32'h0, 32'h510, 32'h0);
      @(negedge clk);
      checkOutput("preflush_count", 64'(count), 64'd5);
      waitCycle();
      flush    = 1'b1;
      in_valid = 2'b11;
      in_instr = {mkAddi(6), mkAddi(7)};
      in_pc    = {32'h518, 32'h514};
      waitCycle();
      flush    = 1'b0;
      in_valid = 2'b00;
      @(negedge clk);
      checkOutput("flush_count", 64'(count), 64'd0);
      checkOutput("flush_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
      waitCycle();

      $display("[TB] simultaneous enqueue and dequeue");
      out_ready = 1'b1;
      pushExp(2'b11, mkAddi(20), mkAddi(21), 32'h600, 32'h604);
      pushExp(2'b11, mkAddi(22), mkAddi(23), 32'h608, 32'h60C);
      applyStimulus(2'b11, mkAddi(20), mkAddi(21), 32'h600, 32'h604);
      applyStimulus(2'b11, mkAddi(22), mkAddi(23), 32'h608, 32'h60C);
      @(negedge clk);
      checkOutput("enq_deq_count", 64'(count), 64'd2);
      waitCycle();
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("enq_deq_drained", 64'(count), 64'd0);
      waitCycle();

      $display("[TB] async reset mid-operation");
      applyStimulus(2'b11, ADDI_X1, ADDI_X2, 32'h700, 32'h704);
      applyStimulus(2'b01, ADDI_X7, 32'h0, 32'h708, 32'h0);
      @(negedge clk);
      checkOutput("prereset_count", 64'(count), 64'd3);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset_count", 64'(count), 64'd0);
      checkOutput("async_reset_valid", 64'(out_valid), 64'd0);
      checkOutput("async_reset_in_ready", 64'(in_ready), 64'd1);
      waitCycle();
      rst = 1'b0;
      applyStimulus(2'b11, mkAddi(24), mkAddi(25), 32'h800, 32'h804);
      @(negedge clk);
      checkOutput("post_reset_count", 64'(count), 64'd2);
      pushExp(2'b11, mkAddi(24), mkAddi(25), 32'h800, 32'h804);
      waitCycle();
      out_ready = 1'b1;
      waitCycle();
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_drained", 64'(count), 64'd0);
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
